// File: rtl/quad_velocity_estimator.sv
// quad_velocity_estimator: samples position at a fixed rate and emits a moving-average velocity over valid/ready
module quad_velocity_estimator #(
  parameter int POS_W      = 32,
  parameter int SAMPLE_DIV = 100000,
  parameter int AVG_LOG2   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [POS_W-1:0] position,
  output logic [POS_W-1:0] velocity,
  output logic             vel_valid,
  input  logic             vel_ready,
  output logic             overrun,
  input  logic             clear_overrun
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = POS_W + AVG_LOG2;
  localparam int CW    = $clog2(SAMPLE_DIV);
  localparam int FW    = AVG_LOG2 + 1;
  localparam int IW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt;
  logic                    strobe, pend, capture, push, load;
  logic [POS_W-1:0]        last_pos;
  logic signed [POS_W-1:0] delta;
  logic signed [POS_W-1:0] ring [DEPTH];
  logic [IW-1:0]           wr;
  logic [FW-1:0]           fill;
  logic signed [SW-1:0]    sum, sum_nx, d_ext, o_ext;

  assign strobe = enable && cnt == CW'(SAMPLE_DIV - 1);

  // sample-rate divider, parked at 0 while disabled
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (!enable || strobe) ? '0 : cnt + CW'(1);

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;

  // next state: capture strobe leaves IDLE, the push that fills the window enters RUN
  always_comb begin
    state_nx = !enable ? IDLE :
               (state == IDLE && strobe) ? PRIME :
               (state == PRIME && push && fill == FW'(DEPTH - 1)) ? RUN : state;
  end

  // control decode and the running-sum update (new delta in, oldest delta out)
  always_comb begin
    capture = state == IDLE && strobe;
    push    = pend && state != IDLE;
    load    = push && (state == RUN || fill == FW'(DEPTH - 1));
    d_ext   = delta;
    o_ext   = ring[wr];
    sum_nx  = sum + d_ext - o_ext;
  end

  // E0 captures position and forms the wrapped delta; E1 rolls it through the window
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend     <= 1'b0;
      last_pos <= '0;
      delta    <= '0;
      wr       <= '0;
      fill     <= '0;
      sum      <= '0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else if (!enable) begin
      pend <= 1'b0;
      wr   <= '0;
      fill <= '0;
      sum  <= '0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else begin
      pend <= strobe && state != IDLE;
      if (capture || (strobe && state != IDLE)) last_pos <= position;
      if (strobe && state != IDLE) delta <= position - last_pos;
      if (push) begin
        ring[wr] <= delta;
        sum      <= sum_nx;
        wr       <= (wr == IW'(DEPTH - 1)) ? '0 : wr + IW'(1);
        if (state == PRIME) fill <= fill + FW'(1);
      end
    end

  // result register with valid/ready handshake and sticky overrun (set beats clear)
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      velocity  <= '0;
      vel_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= (overrun && !clear_overrun) || (enable && load && vel_valid && !vel_ready);
      if (!enable) vel_valid <= 1'b0;
      else begin
        vel_valid <= load || (vel_valid && !vel_ready);
        if (load) velocity <= POS_W'(sum_nx >>> AVG_LOG2);
      end
    end
endmodule

// File: tb/tb_quad_velocity_estimator.sv
// tb_quad_velocity_estimator: directed scoreboard bench for quad_velocity_estimator
module tb_quad_velocity_estimator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        vel_ready = 1'b1;
  logic        clear_overrun = 1'b0;
  logic [31:0] position = '0;
  logic [31:0] velocity;
  logic        vel_valid;
  logic        overrun;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic [31:0] mexp;
  logic [2:0]  tb_cnt;

  quad_velocity_estimator #(.POS_W(32), .SAMPLE_DIV(8), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .position(position),
    .velocity(velocity), .vel_valid(vel_valid), .vel_ready(vel_ready),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  // sample-phase tracker so stimulus can land exactly on strobe edges
  always @(posedge clk or negedge rst)
    if (!rst) tb_cnt <= 3'd0;
    else tb_cnt <= enable ? tb_cnt + 3'd1 : 3'd0;

  // monitor: every accepted result is matched against the scoreboard
  always @(negedge clk)
    if (rst && vel_valid && vel_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %0d, expected no result", $signed(velocity));
      end else begin
        mexp = q.pop_front();
        if (velocity !== mexp) begin
          errors++;
          $display("FAIL velocity: got %0d, expected %0d", $signed(velocity), $signed(mexp));
        end
      end
    end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, $signed(a), $signed(e));
    end
  endtask

  // drive a position, return 1 time unit after the strobe edge that samples it
  task automatic smp(input logic [31:0] p, input logic [31:0] e, input bit v);
    bit s;
    position = p;
    for (int i = 0; i < 16; i++) begin
      s = enable && tb_cnt == 3'd7;
      @(posedge clk);
      #1;
      if (s) break;
    end
    if (v) q.push_back(e);
  endtask

  task automatic restart;
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    #11;
    chk("reset_velocity", velocity, 0);
    chk("reset_valid", {31'd0, vel_valid}, 0);
    chk("reset_overrun", {31'd0, overrun}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    enable = 1'b1;
    // positive ramp +3
    smp(0, 0, 0); smp(3, 0, 0); smp(6, 0, 0); smp(9, 0, 0); smp(12, 3, 1);
    chk("ramp_pre_valid", {31'd0, vel_valid}, 0);
    @(posedge clk);
    #1 chk("ramp_first_valid", {31'd0, vel_valid}, 1);
    smp(15, 3, 1); smp(18, 3, 1);
    // negative ramp then hold
    restart;
    smp(100, 0, 0); smp(95, 0, 0); smp(90, 0, 0); smp(85, 0, 0); smp(80, -5, 1);
    smp(75, -5, 1); smp(75, -4, 1); smp(75, -3, 1); smp(75, -2, 1); smp(75, 0, 1);
    // wrap across the signed boundary
    restart;
    for (int k = 0; k < 7; k++) smp(32'h7FFF_FFF5 + 32'(3 * k), 3, k >= 4);
    // floor rounding
    restart;
    smp(0, 0, 0); smp(4, 0, 0); smp(4, 0, 0); smp(4, 0, 0); smp(4, 1, 1);
    restart;
    smp(10, 0, 0); smp(9, 0, 0); smp(9, 0, 0); smp(9, 0, 0); smp(9, -1, 1);
    // overrun, clear, and transfer coinciding with a new result
    restart;
    vel_ready = 1'b0;
    smp(0, 0, 0); smp(2, 0, 0); smp(4, 0, 0); smp(6, 0, 0); smp(8, 0, 0); smp(14, 3, 1);
    @(posedge clk);
    #1;
    chk("ovr_set", {31'd0, overrun}, 1);
    chk("ovr_velocity", velocity, 3);
    chk("ovr_valid", {31'd0, vel_valid}, 1);
    clear_overrun = 1'b1;
    @(posedge clk);
    #1 clear_overrun = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 0);
    vel_ready = 1'b1;
    @(posedge clk);
    #1 vel_ready = 1'b0;
    smp(20, 4, 1); smp(20, 3, 1);
    vel_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("xfer_load_overrun", {31'd0, overrun}, 0);
    chk("xfer_load_valid", {31'd0, vel_valid}, 1);
    // disable in RUN, then full refill
    restart;
    vel_ready = 1'b0;
    smp(0, 0, 0); smp(1, 0, 0); smp(2, 0, 0); smp(3, 0, 0); smp(4, 0, 0);
    @(posedge clk);
    #1 chk("run_valid", {31'd0, vel_valid}, 1);
    enable = 1'b0;
    @(posedge clk);
    #1 chk("disable_valid", {31'd0, vel_valid}, 0);
    vel_ready = 1'b1;
    enable = 1'b1;
    smp(10, 0, 0); smp(11, 0, 0); smp(12, 0, 0); smp(13, 0, 0); smp(14, 1, 1);
    // reset between E0 and E1
    restart;
    vel_ready = 1'b0;
    smp(0, 0, 0); smp(7, 0, 0); smp(14, 0, 0); smp(21, 0, 0); smp(28, 0, 0); smp(35, 0, 0);
    smp(42, 0, 0);
    rst = 1'b0;
    #1;
    chk("midrst_velocity", velocity, 0);
    chk("midrst_valid", {31'd0, vel_valid}, 0);
    chk("midrst_overrun", {31'd0, overrun}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    vel_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
